// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES gamepad reader/responder pair.
package nes_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

  localparam int unsigned PAD_BITS   = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe, plus rise/fall pulse detection.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Controller-side NES pad emulation: answers latch/ctrl_clk strobes and shifts out btn_in, active-low.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PAD_BITS-1:0]    btn_in,
  input  logic                   latch,
  input  logic                   ctrl_clk,
  output logic                   data,
  output logic                   busy,
  output logic [PAD_BITS-1:0]    snapshot,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   proto_err
);

  logic latch_level, latch_rise, latch_fall;
  logic clk_level, clk_rise, clk_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (latch),
    .level   (latch_level),
    .rise    (latch_rise),
    .fall    (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (ctrl_clk),
    .level   (clk_level),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, latch_level, clk_level, clk_fall};

  pad_state_t             state_q, state_n;
  logic [PAD_BITS-1:0]    sr_q, sr_n;
  logic [2:0]             cnt_q, cnt_n;
  logic [PAD_BITS-1:0]    snap_q, snap_n;
  logic [FRAME_CNT_W-1:0] fc_q, fc_n;
  logic                   err_q, err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sr_q    <= sr_n;
      cnt_q   <= cnt_n;
      snap_q  <= snap_n;
      fc_q    <= fc_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sr_n    = sr_q;
    cnt_n   = cnt_q;
    snap_n  = snap_q;
    fc_n    = fc_q;
    err_n   = err_q;

    unique case (state_q)
      IDLE: begin
        sr_n = '0;
        if (latch_rise) begin
          state_n = LOAD;
          sr_n    = btn_in;
        end else if (clk_rise) begin
          err_n = 1'b1;
        end
      end

      LOAD: begin
        // Transparent parallel load; the last tracked value is what shifts out.
        sr_n = btn_in;
        if (latch_fall) begin
          snap_n  = btn_in;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        // Latch beats a coincident clock edge, so it is tested first.
        if (latch_rise) begin
          err_n   = 1'b1;
          sr_n    = btn_in;
          state_n = LOAD;
        end else if (clk_rise) begin
          sr_n  = {1'b0, sr_q[PAD_BITS-1:1]};
          cnt_n = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_n = DONE;
            fc_n    = fc_q + FRAME_CNT_W'(1);
          end
        end
      end

      DONE: begin
        sr_n = '0;
        if (latch_rise) begin
          sr_n    = btn_in;
          state_n = LOAD;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign data        = ~sr_q[0];
  assign busy        = (state_q == SHIFT);
  assign snapshot    = snap_q;
  assign frame_count = fc_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench: drives latch/ctrl_clk like a reader and scoreboards the serial data bits.
module tb_nes_pad_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  btn_in;
  logic        latch;
  logic        ctrl_clk;
  logic        data;
  logic        busy;
  logic [7:0]  snapshot;
  logic [15:0] frame_count;
  logic        proto_err;

  int unsigned n_checks;
  int unsigned n_errors;
  logic        exp_q[$];
  logic [15:0] exp_fc;

  nes_pad_responder #(.SYNC_STAGES(2), .FRAME_CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .latch       (latch),
    .ctrl_clk    (ctrl_clk),
    .data        (data),
    .busy        (busy),
    .snapshot    (snapshot),
    .frame_count (frame_count),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data"},     32'(data),        32'd1);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_snapshot"}, 32'(snapshot),    32'd0);
    chk({tag, "_fc"},       32'(frame_count), 32'd0);
    chk({tag, "_err"},      32'(proto_err),   32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_fc = '0;
    exp_q.delete();
  endtask

  // Full latch pulse; the scoreboard expects the active-low image of btn bit 0..7.
  task automatic do_latch(input logic [7:0] btn);
    btn_in = btn;
    latch  = 1'b1;
    tick(10);
    latch  = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(~btn[i]);
    tick(10);
  endtask

  task automatic read_bits(input int unsigned n);
    logic e;
    for (int unsigned k = 0; k < n; k++) begin
      if (exp_q.size() == 0) e = 1'b1;
      else e = exp_q.pop_front();
      chk("data_bit", 32'(data), 32'(e));
      ctrl_clk = 1'b1;
      tick(10);
      ctrl_clk = 1'b0;
      tick(10);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    btn_in   = '0;
    latch    = 1'b0;
    ctrl_clk = 1'b0;
    do_reset();
    check_reset_values("reset");

    // Clock pulse with no latch is a protocol error.
    ctrl_clk = 1'b1; tick(10);
    ctrl_clk = 1'b0; tick(10);
    chk("nolatch_err",  32'(proto_err),   32'd1);
    chk("nolatch_data", 32'(data),        32'd1);
    chk("nolatch_fc",   32'(frame_count), 32'd0);
    do_reset();
    chk("err_cleared", 32'(proto_err), 32'd0);

    // 0xA5 frame, then two extra pulses that must read as released.
    do_latch(8'hA5);
    chk("a5_busy", 32'(busy), 32'd1);
    read_bits(8);
    exp_fc++;
    chk("a5_fc",       32'(frame_count), 32'(exp_fc));
    chk("a5_busy_end", 32'(busy),        32'd0);
    chk("a5_snapshot", 32'(snapshot),    32'hA5);
    read_bits(2);
    chk("a5_extra_fc", 32'(frame_count), 32'(exp_fc));

    // Buttons change while latch is held: the final value is captured.
    btn_in = 8'h00;
    latch  = 1'b1;
    tick(10);
    btn_in = 8'hFF;
    tick(10);
    latch  = 1'b0;
    tick(10);
    chk("ff_snapshot", 32'(snapshot), 32'hFF);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    read_bits(8);
    exp_fc++;
    chk("ff_fc",  32'(frame_count), 32'(exp_fc));
    chk("ff_err", 32'(proto_err),   32'd0);

    // Re-latch after three shifts.
    do_latch(8'h3C);
    read_bits(3);
    exp_q.delete();
    do_latch(8'hC3);
    chk("relatch_err", 32'(proto_err),   32'd1);
    chk("relatch_fc",  32'(frame_count), 32'(exp_fc));
    read_bits(8);
    exp_fc++;
    chk("relatch_next_fc",   32'(frame_count), 32'(exp_fc));
    chk("relatch_next_snap", 32'(snapshot),    32'hC3);

    // Reset arriving on the fourth shift.
    do_reset();
    do_latch(8'h5A);
    read_bits(3);
    ctrl_clk = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reset_values("midreset");
    ctrl_clk = 1'b0;
    do_reset();
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
